dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock port is named CLK and the reset port is named Reset.
REQ-002 Parameter WAIT_STATES, default 2, SHALL set the wait cycles inserted before each response (legal 0..7).
REQ-003 Parameter DEPTH_WORDS, default 256, SHALL set the 32-bit word storage depth (power of two).
REQ-004 Port CLK, input, 1 bit, SHALL be the rising-edge clock.
REQ-005 Port Reset, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-006 Port MemReq, input, 1 bit, SHALL mark a data-memory request from the CPU memory stage.
REQ-007 Port MemWrite, input, 1 bit, SHALL select a write (1) or read (0).
REQ-008 Port AddrData, input, 32 bits, SHALL carry the byte address.
REQ-009 Port WriteData, input, 32 bits, SHALL carry the store data.
REQ-010 Port ReadData, output, 32 bits, SHALL carry the load data.
REQ-011 Port MemReady, output, 1 bit, SHALL pulse for one cycle to complete a request.
REQ-012 Port MemStall, output, 1 bit, SHALL request a pipeline freeze from the hazard unit.
REQ-013 Port AddrErr, output, 1 bit, SHALL flag a misaligned or out-of-range access, valid with MemReady.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT, and RESP.
REQ-015 In IDLE with MemReq=1, the block SHALL latch MemWrite, AddrData, and WriteData at the clock edge.
- It SHALL go to WAIT, loading the wait counter with WAIT_STATES-1.
- If WAIT_STATES=0, it SHALL go directly to RESP.
REQ-016 In WAIT, the counter SHALL decrement each cycle; at count 0 the FSM SHALL go to RESP.
REQ-017 RESP SHALL last exactly one cycle, with MemReady=1, and then return to IDLE unconditionally.
REQ-018 Latency: taking the sampling cycle as cycle 0, MemReady SHALL be high in cycle WAIT_STATES+1.
REQ-019 New requests SHALL be accepted only in IDLE, so back-to-back requests are separated by at least one cycle.
REQ-020 Inputs SHALL be ignored outside IDLE; the latched copies SHALL govern the transaction.
REQ-021 Deasserting MemReq mid-transaction SHALL NOT abort the transaction; it SHALL still complete with its MemReady pulse.
REQ-022 MemStall SHALL equal MemReq AND NOT MemReady (combinational), so MemStall is low in the RESP cycle.
REQ-023 Word index SHALL be latched address bits [log2(DEPTH_WORDS)+1:2].
REQ-024 Error condition: latched address bits [1:0] != 0, or any address bit above the index range set.
REQ-025 Write handling:
- A legal write SHALL commit to storage on the edge entering RESP.
- An erroneous write SHALL NOT modify storage.
REQ-026 Read handling:
- A legal read SHALL register storage data into ReadData on the edge entering RESP.
- An erroneous read SHALL load ReadData=0.
REQ-027 ReadData SHALL hold its value until the next read response; write responses SHALL leave ReadData unchanged.
REQ-028 AddrErr SHALL be updated on the edge entering RESP and held until the next response.
REQ-029 A read of a word written by the immediately preceding transaction SHALL return the new data.

Reset
REQ-030 Reset low SHALL immediately force the following, independent of CLK:
- FSM to IDLE and wait counter to 0;
- ReadData=0, MemReady=0, AddrErr=0;
- latched request registers to 0.
REQ-031 Reset mid-transaction SHALL discard the pending request without a write or a MemReady pulse.
REQ-032 Storage contents SHALL NOT be cleared by reset.
REQ-033 After Reset rises, the first request SHALL be accepted at the first rising edge with MemReq=1.

Verification
REQ-034 With WAIT_STATES=2: write 0x00000010 <- 0xDEADBEEF, then read 0x10.
- Response: MemReady in cycle 3 of each request; ReadData=0xDEADBEEF; AddrErr=0.
REQ-035 With WAIT_STATES=0: read 0x10 after the write above.
- Response: MemReady in cycle 1; MemStall high only in cycle 0.
REQ-036 Misaligned write to 0x00000012 <- 0x12345678:
- Response: AddrErr=1 with MemReady.
- A following read of 0x10 SHALL return the prior value unchanged.
REQ-037 Out-of-range read of 0x00000400 (DEPTH_WORDS=256):
- Response: AddrErr=1, ReadData=0.
REQ-038 Assert Reset low in WAIT of a write 0x20 <- 0xCAFEF00D:
- Response: outputs go to 0 immediately and no MemReady occurs.
- A later read of 0x20 SHALL return the pre-reset contents.
REQ-039 Drop MemReq and change AddrData in WAIT:
- Response: the transaction completes at the original address with one MemReady pulse.

Source files
------------

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//   Bundles the data-memory request/response signals that pass between the
//   CPU memory stage and the data-memory responder.
//
//   Signals
//     MemReq    : request strobe from the CPU memory stage
//     MemWrite  : 1 = store, 0 = load
//     AddrData  : byte address
//     WriteData : store data
//     ReadData  : load data (held until the next load response)
//     MemReady  : one-cycle completion pulse
//     MemStall  : pipeline-freeze request to the hazard unit
//     AddrErr   : misaligned / out-of-range flag, valid with MemReady
//
//   Modports
//     master : CPU side (drives the request, observes the response)
//     slave  : responder side
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] AddrData;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemStall;
  logic        AddrErr;

  modport master (
    output MemReq,
    output MemWrite,
    output AddrData,
    output WriteData,
    input  ReadData,
    input  MemReady,
    input  MemStall,
    input  AddrErr
  );

  modport slave (
    input  MemReq,
    input  MemWrite,
    input  AddrData,
    input  WriteData,
    output ReadData,
    output MemReady,
    output MemStall,
    output AddrErr
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for a pipelined CPU. A request is sampled in IDLE,
//   a programmable number of wait cycles is inserted, and the response is
//   delivered in a single RESP cycle with a one-cycle MemReady pulse.
//   Storage is a word array with a registered read port.
//
//   Parameters
//     WAIT_STATES : wait cycles before each response (0..7)
//     DEPTH_WORDS : number of 32-bit words of storage (power of two)
//
//   Ports
//     CLK   : rising-edge clock
//     Reset : asynchronous, active-low reset
//     bus   : request/response bundle (slave side), see dmem_responder_if
//
//   Timing: with the request-sampling cycle as cycle 0, MemReady is high in
//   cycle WAIT_STATES+1. Writes commit and reads are registered on the edge
//   that enters RESP; ReadData and AddrErr then hold until the next response
//   (ReadData only changes on read responses).
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic             CLK,
  input  logic             Reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  // Reload value for the wait counter; unused when WAIT_STATES is 0.
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  // Any set bit under this mask makes an address illegal: the two byte-offset
  // bits, plus every bit above the word-index field.
  localparam logic [31:0] ADDR_SPAN = 32'(DEPTH_WORDS * 4);
  localparam logic [31:0] ERR_MASK  = ~(ADDR_SPAN - 32'd1) | 32'h0000_0003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [2:0]  count_reg;
  logic [2:0]  count_next;

  // Latched request
  logic        write_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;

  // Response registers
  logic [31:0] rdata_reg;
  logic        err_reg;

  // Storage (not reset)
  logic [31:0] mem [DEPTH_WORDS];

  // Transaction view. With WAIT_STATES=0 the edge that samples the request is
  // also the edge that enters RESP, so the latched copies are not yet valid;
  // in IDLE the live bus inputs stand in for them. Outside IDLE only the
  // latched copies are used, so bus activity mid-transaction is ignored.
  logic             in_idle;
  logic             cur_write;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic             cur_err;
  logic [IDX_W-1:0] cur_idx;
  logic             enter_resp;
  logic             accept;
  logic             mem_ready;

  assign in_idle   = (state_reg == IDLE);
  assign accept    = in_idle && bus.MemReq;
  assign cur_write = in_idle ? bus.MemWrite  : write_reg;
  assign cur_addr  = in_idle ? bus.AddrData  : addr_reg;
  assign cur_wdata = in_idle ? bus.WriteData : wdata_reg;
  assign cur_err   = |(cur_addr & ERR_MASK);
  assign cur_idx   = cur_addr[IDX_W+1:2];

  // RESP always exits to IDLE, so a RESP next state is always an entry.
  assign enter_resp = (state_next == RESP);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
      count_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (bus.MemReq) begin
          if (WAIT_STATES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            count_next = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (count_reg == 3'd0) begin
          state_next = RESP;
        end else begin
          count_next = count_reg - 3'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = 3'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request latch
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      write_reg <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
    end else if (accept) begin
      write_reg <= bus.MemWrite;
      addr_reg  <= bus.AddrData;
      wdata_reg <= bus.WriteData;
    end
  end

  // -------------------------------------------------------------------------
  // Storage write port. A reset that lands mid-transaction returns the FSM to
  // IDLE, which removes the pending RESP entry and so the write with it.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (enter_resp && cur_write && !cur_err) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Response registers. Writes complete before the next transaction can be
  // sampled, so a following read of the same word sees the new data.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rdata_reg <= 32'd0;
    end else if (enter_resp && !cur_write) begin
      rdata_reg <= cur_err ? 32'd0 : mem[cur_idx];
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      err_reg <= 1'b0;
    end else if (enter_resp) begin
      err_reg <= cur_err;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem_ready    = (state_reg == RESP);
  assign bus.MemReady = mem_ready;
  assign bus.ReadData = rdata_reg;
  assign bus.AddrErr  = err_reg;
  assign bus.MemStall = bus.MemReq && !mem_ready;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Directed, table-driven bench for dmem_responder. One instance runs with
//   WAIT_STATES=2 (bus2) and one with WAIT_STATES=0 (bus0); both share the
//   clock and reset. Hand-written sequences cover reset during a wait and
//   request withdrawal mid-transaction.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  logic CLK;
  logic Reset;

  dmem_responder_if bus2 ();
  dmem_responder_if bus0 ();

  dmem_responder #(.WAIT_STATES(2), .DEPTH_WORDS(256)) dut2 (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus2)
  );

  dmem_responder #(.WAIT_STATES(0), .DEPTH_WORDS(256)) dut0 (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit s0, input bit req, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (s0) begin
      bus0.MemReq = req; bus0.MemWrite = wr; bus0.AddrData = addr; bus0.WriteData = wdata;
    end else begin
      bus2.MemReq = req; bus2.MemWrite = wr; bus2.AddrData = addr; bus2.WriteData = wdata;
    end
  endtask

  function automatic logic get_ready(input bit s0);
    return s0 ? bus0.MemReady : bus2.MemReady;
  endfunction
  function automatic logic get_stall(input bit s0);
    return s0 ? bus0.MemStall : bus2.MemStall;
  endfunction
  function automatic logic get_err(input bit s0);
    return s0 ? bus0.AddrErr : bus2.AddrErr;
  endfunction
  function automatic logic [31:0] get_rdata(input bit s0);
    return s0 ? bus0.ReadData : bus2.ReadData;
  endfunction

  // One complete request: MemReq held until MemReady, then dropped.
  task automatic do_txn(input bit s0, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input bit exp_err);
    int cyc;
    int exp_lat;
    bit got;
    bit stall_ok;
    exp_lat = s0 ? 1 : 3;
    @(negedge CLK);
    drive(s0, 1'b1, wr, addr, wdata);
    #1;
    stall_ok = (get_stall(s0) === 1'b1);   // cycle 0 must stall
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge CLK);
      cyc++;
      if (get_ready(s0) === 1'b1) got = 1'b1;
      else if (get_stall(s0) !== 1'b1) stall_ok = 1'b0;
    end
    if (got && get_stall(s0) !== 1'b0) stall_ok = 1'b0;  // no stall in RESP
    check("latency", got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
    check("stall", {31'd0, stall_ok}, 32'd1);
    check("rdata", get_rdata(s0), exp_rd);
    check("addrerr", {31'd0, get_err(s0)}, {31'd0, exp_err});
    $display("txn ws=%0d %s addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             s0 ? 0 : 2, wr ? "WR" : "RD", addr, wdata, get_rdata(s0), get_err(s0), cyc);
    drive(s0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int pulse_cyc;
    logic [31:0] cap_rd;
    logic cap_err;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0012, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1111_1111, 1'b0};
    vecs[9]  = '{1'b1, 32'h8000_0010, 32'h0000_0000, 32'h1111_1111, 1'b1};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_0012, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1};

    Reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge CLK);
    check("rst_rdata", bus2.ReadData, 32'd0);
    check("rst_ready", {31'd0, bus2.MemReady}, 32'd0);
    check("rst_err", {31'd0, bus2.AddrErr}, 32'd0);
    check("rst_stall", {31'd0, bus2.MemStall}, 32'd0);
    Reset = 1'b1;

    // Table vectors on the WAIT_STATES=2 instance
    for (int i = 0; i < 14; i++) begin
      do_txn(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err);
    end

    // Reset asserted while a write to 0x20 sits in WAIT
    @(negedge CLK);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    @(posedge CLK);
    #2;
    Reset = 1'b0;
    #1;
    check("rstmid_rdata", bus2.ReadData, 32'd0);
    check("rstmid_ready", {31'd0, bus2.MemReady}, 32'd0);
    check("rstmid_err", {31'd0, bus2.AddrErr}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge CLK);
      if (bus2.MemReady === 1'b1) pulses++;
    end
    Reset = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      if (bus2.MemReady === 1'b1) pulses++;
    end
    check("rstmid_no_ready", 32'(pulses), 32'd0);
    $display("txn ws=2 reset during WAIT of WR 0x20 <- cafef00d, pulses=%0d", pulses);
    do_txn(1'b0, 1'b0, 32'h0000_0020, 32'd0, 32'h1111_1111, 1'b0);

    // MemReq dropped and AddrData changed while in WAIT
    do_txn(1'b0, 1'b1, 32'h0000_0040, 32'h4444_4444, 32'h1111_1111, 1'b0);
    do_txn(1'b0, 1'b1, 32'h0000_0030, 32'h3333_3333, 32'h1111_1111, 1'b0);
    @(negedge CLK);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0030, 32'd0);
    @(negedge CLK);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'd0);
    pulses = 0;
    pulse_cyc = -1;
    cap_rd = 32'd0;
    cap_err = 1'b1;
    for (int c = 2; c <= 9; c++) begin
      @(negedge CLK);
      if (bus2.MemReady === 1'b1) begin
        pulses++;
        pulse_cyc = c;
        cap_rd = bus2.ReadData;
        cap_err = bus2.AddrErr;
      end
    end
    check("drop_pulses", 32'(pulses), 32'd1);
    check("drop_cycle", 32'(pulse_cyc), 32'd3);
    check("drop_rdata", cap_rd, 32'h3333_3333);
    check("drop_err", {31'd0, cap_err}, 32'd0);
    $display("txn ws=2 RD 0x30 with MemReq dropped in WAIT -> rdata=%h pulses=%0d", cap_rd, pulses);
    do_txn(1'b0, 1'b0, 32'h0000_0040, 32'd0, 32'h4444_4444, 1'b0);

    // WAIT_STATES=0 instance
    do_txn(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    do_txn(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
    do_txn(1'b1, 1'b1, 32'h0000_0012, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1);
    do_txn(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
    do_txn(1'b1, 1'b0, 32'h0000_0400, 32'd0, 32'h0000_0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
